// File: rtl/wm_panel_input_if.sv
// Panel bundle: raw buttons and busy from the machine in, conditioned pulses and levels out.
interface wm_panel_input_if;
  logic       start_raw;
  logic       cancel_raw;
  logic       lid_raw;
  logic [2:0] mode_raw;
  logic       busy;
  logic       start;
  logic       cancel;
  logic       lid;
  logic       mode1;
  logic       mode2;
  logic       mode3;
  logic       err_lid;
  logic       err_nobusy;
  logic [1:0] panel_state;

  modport master (
    output start_raw, cancel_raw, lid_raw, mode_raw, busy,
    input  start, cancel, lid, mode1, mode2, mode3, err_lid, err_nobusy, panel_state
  );

  modport slave (
    input  start_raw, cancel_raw, lid_raw, mode_raw, busy,
    output start, cancel, lid, mode1, mode2, mode3, err_lid, err_nobusy, panel_state
  );
endinterface

// File: rtl/wm_panel_input.sv
// Front-panel conditioner: 2-flop sync + debounce, one-hot mode latch, start/cancel gating FSM.
// Latency: raw to debounced level 2+DEBOUNCE_CYCLES edges, event pulses one edge later; no backpressure.
module wm_panel_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int BUSY_WAIT       = 4
) (
  input logic             clk,
  input logic             rst_n,
  wm_panel_input_if.slave pif
);
  // Bit order of the conditioned vector: {mode[2:0], lid, cancel, start}
  localparam int              NB      = 6;
  localparam logic [NB-1:0]   RST_VAL = 6'b000100;
  localparam int              WAIT_W  = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READY     = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [NB-1:0]             raw;
  logic [NB-1:0]             sync1;
  logic [NB-1:0]             sync2;
  logic [NB-1:0]             deb;
  logic [NB-1:0]             flip;
  logic [NB-1:0][CNT_W-1:0]  cnt;
  logic [1:0]                evt_prev;

  state_t            state, state_nxt;
  logic [2:0]        mode_q, mode_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              start_q, start_nxt;
  logic              cancel_q, cancel_nxt;
  logic              err_lid_q, err_lid_nxt;
  logic              err_nobusy_q, err_nobusy_nxt;

  logic              start_rise;
  logic              cancel_rise;
  logic [2:0]        mode_new;

  assign raw = {pif.mode_raw, pif.lid_raw, pif.cancel_raw, pif.start_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level flips on the edge where the disagreement run reaches DEBOUNCE_CYCLES.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NB; i++) begin
      flip[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb      <= RST_VAL;
      cnt      <= '0;
      evt_prev <= '0;
    end else begin
      deb      <= deb ^ flip;
      evt_prev <= deb[1:0];
      for (int i = 0; i < NB; i++) begin
        if ((sync2[i] == deb[i]) || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign start_rise  = deb[0] & ~evt_prev[0];
  assign cancel_rise = deb[1] & ~evt_prev[1];
  // Mode selection latches on the same edge the debounced level rises.
  assign mode_new    = flip[5:3] & ~deb[5:3];

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode_q;
    wait_nxt       = wait_cnt;
    start_nxt      = 1'b0;
    cancel_nxt     = 1'b0;
    err_lid_nxt    = 1'b0;
    err_nobusy_nxt = 1'b0;

    if (((state == IDLE) || (state == READY)) && (mode_new != 3'b000)) begin
      if (mode_new[0])      mode_nxt = 3'b001;
      else if (mode_new[1]) mode_nxt = 3'b010;
      else                  mode_nxt = 3'b100;
    end

    case (state)
      IDLE: begin
        cancel_nxt = cancel_rise;
        if (mode_q != 3'b000) state_nxt = READY;
      end
      READY: begin
        if (cancel_rise) begin
          cancel_nxt = 1'b1;
          mode_nxt   = 3'b000;
          state_nxt  = IDLE;
        end else if (start_rise) begin
          if (deb[2]) begin
            err_lid_nxt = 1'b1;
          end else if (!pif.busy) begin
            start_nxt = 1'b1;
            state_nxt = WAIT_BUSY;
            wait_nxt  = WAIT_W'(BUSY_WAIT);
          end
        end
      end
      WAIT_BUSY: begin
        cancel_nxt = cancel_rise;
        if (pif.busy) begin
          state_nxt = RUN;
        end else if (wait_cnt <= WAIT_W'(1)) begin
          err_nobusy_nxt = 1'b1;
          state_nxt      = READY;
        end else begin
          wait_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      RUN: begin
        cancel_nxt = cancel_rise;
        if (!pif.busy) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_q       <= 3'b000;
      wait_cnt     <= '0;
      start_q      <= 1'b0;
      cancel_q     <= 1'b0;
      err_lid_q    <= 1'b0;
      err_nobusy_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode_q       <= mode_nxt;
      wait_cnt     <= wait_nxt;
      start_q      <= start_nxt;
      cancel_q     <= cancel_nxt;
      err_lid_q    <= err_lid_nxt;
      err_nobusy_q <= err_nobusy_nxt;
    end
  end

  assign pif.start       = start_q;
  assign pif.cancel      = cancel_q;
  assign pif.lid         = deb[2];
  assign pif.mode1       = mode_q[0];
  assign pif.mode2       = mode_q[1];
  assign pif.mode3       = mode_q[2];
  assign pif.err_lid     = err_lid_q;
  assign pif.err_nobusy  = err_nobusy_q;
  assign pif.panel_state = state;
endmodule
